// File: rtl/rop_pkg.sv
// ---------------------------------------------------------------------------
// rop_pkg
// Shared types for the fragment depth ROP: the depth compare function codes
// as driven on the depth_func configuration input, and the ROP state machine
// encoding.
// ---------------------------------------------------------------------------
package rop_pkg;

    localparam int ZFUNC_W = 3;

    // Depth compare functions, numbered exactly as the depth_func input encodes them
    typedef enum logic [ZFUNC_W-1:0] {
        ZF_NEVER    = 3'd0,
        ZF_LESS     = 3'd1,
        ZF_EQUAL    = 3'd2,
        ZF_LEQUAL   = 3'd3,
        ZF_GREATER  = 3'd4,
        ZF_NOTEQUAL = 3'd5,
        ZF_GEQUAL   = 3'd6,
        ZF_ALWAYS   = 3'd7
    } depth_func_t;

    // One fragment in flight: read Z, compare, then write
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ZREQ,
        ST_ZWAIT,
        ST_TEST,
        ST_WRITE
    } rop_state_t;

endpackage

// File: rtl/frag_rop_depth_cmp.sv
// ---------------------------------------------------------------------------
// frag_rop_depth_cmp
// Purely combinational depth test: compares the incoming fragment depth
// against the depth stored in the Z buffer (unsigned) using the selected
// compare function.
// Ports:
//   func_i     depth compare function
//   fragZ_i    fragment depth
//   storedZ_i  depth read back from the Z buffer
//   pass_o     1 when the fragment survives the test
// ---------------------------------------------------------------------------
module frag_rop_depth_cmp
    import rop_pkg::*;
#(
    parameter int COORD_W = 16
) (
    input  depth_func_t        func_i,
    input  logic [COORD_W-1:0] fragZ_i,
    input  logic [COORD_W-1:0] storedZ_i,
    output logic               pass_o
);

    logic isLess;
    logic isEqual;

    assign isLess  = (fragZ_i < storedZ_i);
    assign isEqual = (fragZ_i == storedZ_i);

    // Every function is a combination of "less" and "equal"; greater is neither
    always_comb begin
        pass_o = 1'b0;
        case (func_i)
            ZF_NEVER:    pass_o = 1'b0;
            ZF_LESS:     pass_o = isLess;
            ZF_EQUAL:    pass_o = isEqual;
            ZF_LEQUAL:   pass_o = isLess | isEqual;
            ZF_GREATER:  pass_o = ~(isLess | isEqual);
            ZF_NOTEQUAL: pass_o = ~isEqual;
            ZF_GEQUAL:   pass_o = ~isLess;
            ZF_ALWAYS:   pass_o = 1'b1;
            default:     pass_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/frag_depth_rop.sv
// ---------------------------------------------------------------------------
// frag_depth_rop
// Fragment sink between the rasterizer/shader output and the framebuffer
// memory arbiter. Each accepted fragment optionally has its depth tested
// against the Z buffer (read request, wait for data, compare), and on pass
// the colour word (and optionally the new depth) is written out on two
// independent write ports. Only one fragment is in flight at a time.
//
// Optional feature: define FRAG_ROP_SCISSOR_EN to add a scissor rectangle
// (sc_x, sc_y, sc_w, sc_h). Fragments outside it are accepted and dropped
// immediately with no memory traffic.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   frag_valid/frag_ready         fragment handshake
//   frag_x/y/z, frag_color        fragment payload
//   depth_test_en, depth_func,
//   depth_write_en                depth configuration (latched per fragment)
//   fb_pitch, z_base, c_base      framebuffer layout (latched per fragment)
//   zrd_req_*, zrd_addr           Z read request channel
//   zrd_rsp_valid/data            Z read response (in order, latency >= 1)
//   zwr_*                         Z write channel
//   cwr_*                         colour write channel
//   perf_frags_in/passed/killed   wrapping event counters
// ---------------------------------------------------------------------------
module frag_depth_rop
    import rop_pkg::*;
#(
    parameter int COORD_W = 16,
    parameter int COLOR_W = 32,
    parameter int ADDR_W  = 24
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               frag_valid,
    output logic               frag_ready,
    input  logic [COORD_W-1:0] frag_x,
    input  logic [COORD_W-1:0] frag_y,
    input  logic [COORD_W-1:0] frag_z,
    input  logic [COLOR_W-1:0] frag_color,
    input  logic               depth_test_en,
    input  logic [ZFUNC_W-1:0] depth_func,
    input  logic               depth_write_en,
    input  logic [COORD_W-1:0] fb_pitch,
    input  logic [ADDR_W-1:0]  z_base,
    input  logic [ADDR_W-1:0]  c_base,
`ifdef FRAG_ROP_SCISSOR_EN
    input  logic [COORD_W-1:0] sc_x,
    input  logic [COORD_W-1:0] sc_y,
    input  logic [COORD_W-1:0] sc_w,
    input  logic [COORD_W-1:0] sc_h,
`endif
    output logic               zrd_req_valid,
    input  logic               zrd_req_ready,
    output logic [ADDR_W-1:0]  zrd_addr,
    input  logic               zrd_rsp_valid,
    input  logic [COORD_W-1:0] zrd_rsp_data,
    output logic               zwr_valid,
    input  logic               zwr_ready,
    output logic [ADDR_W-1:0]  zwr_addr,
    output logic [COORD_W-1:0] zwr_data,
    output logic               cwr_valid,
    input  logic               cwr_ready,
    output logic [ADDR_W-1:0]  cwr_addr,
    output logic [COLOR_W-1:0] cwr_data,
    output logic [31:0]        perf_frags_in,
    output logic [31:0]        perf_frags_passed,
    output logic [31:0]        perf_frags_killed
);

    rop_state_t         state_q;
    logic [COORD_W-1:0] fragZ_q;
    logic [COORD_W-1:0] storedZ_q;
    logic [COLOR_W-1:0] color_q;
    depth_func_t        func_q;
    logic               zWriteEn_q;
    logic [ADDR_W-1:0]  zAddr_q;
    logic [ADDR_W-1:0]  cAddr_q;
    logic               zrdValid_q;
    logic [ADDR_W-1:0]  zrdAddr_q;
    logic               zwrValid_q;
    logic [ADDR_W-1:0]  zwrAddr_q;
    logic [COORD_W-1:0] zwrData_q;
    logic               cwrValid_q;
    logic [ADDR_W-1:0]  cwrAddr_q;
    logic [COLOR_W-1:0] cwrData_q;
    logic               zDone_q;
    logic               cDone_q;
    logic [31:0]        perfIn_q;
    logic [31:0]        perfPassed_q;
    logic [31:0]        perfKilled_q;

    logic [ADDR_W-1:0]  offset_d;
    logic [ADDR_W-1:0]  zAddr_d;
    logic [ADDR_W-1:0]  cAddr_d;
    logic               scissorKeep;
    logic               depthPass;
    logic               zDoneNow;
    logic               cDoneNow;

    // Pixel offset wraps modulo the address space; operands are widened first
    // so the product is formed at address width rather than coordinate width
    assign offset_d = ADDR_W'(frag_y) * ADDR_W'(fb_pitch) + ADDR_W'(frag_x);
    assign zAddr_d  = z_base + offset_d;
    assign cAddr_d  = c_base + offset_d;

`ifdef FRAG_ROP_SCISSOR_EN
    // One extra bit on the rectangle ends so a rectangle touching 2^COORD_W does not wrap
    logic [COORD_W:0] scXEnd;
    logic [COORD_W:0] scYEnd;
    assign scXEnd      = {1'b0, sc_x} + {1'b0, sc_w};
    assign scYEnd      = {1'b0, sc_y} + {1'b0, sc_h};
    assign scissorKeep = (frag_x >= sc_x) && ({1'b0, frag_x} < scXEnd) &&
                         (frag_y >= sc_y) && ({1'b0, frag_y} < scYEnd);
`else
    assign scissorKeep = 1'b1;
`endif

    frag_rop_depth_cmp #(
        .COORD_W (COORD_W)
    ) uDepthCmp (
        .func_i    (func_q),
        .fragZ_i   (fragZ_q),
        .storedZ_i (storedZ_q),
        .pass_o    (depthPass)
    );

    // A channel counts as done once its handshake has happened, including this cycle's
    assign zDoneNow = zDone_q | (zwrValid_q & zwr_ready);
    assign cDoneNow = cDone_q | (cwrValid_q & cwr_ready);

    assign frag_ready        = (state_q == ST_IDLE);
    assign zrd_req_valid     = zrdValid_q;
    assign zrd_addr          = zrdAddr_q;
    assign zwr_valid         = zwrValid_q;
    assign zwr_addr          = zwrAddr_q;
    assign zwr_data          = zwrData_q;
    assign cwr_valid         = cwrValid_q;
    assign cwr_addr          = cwrAddr_q;
    assign cwr_data          = cwrData_q;
    assign perf_frags_in     = perfIn_q;
    assign perf_frags_passed = perfPassed_q;
    assign perf_frags_killed = perfKilled_q;

    // Main sequencer; all channel outputs are registered here so they hold
    // steady while a handshake is stalled
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            fragZ_q      <= '0;
            storedZ_q    <= '0;
            color_q      <= '0;
            func_q       <= ZF_NEVER;
            zWriteEn_q   <= 1'b0;
            zAddr_q      <= '0;
            cAddr_q      <= '0;
            zrdValid_q   <= 1'b0;
            zrdAddr_q    <= '0;
            zwrValid_q   <= 1'b0;
            zwrAddr_q    <= '0;
            zwrData_q    <= '0;
            cwrValid_q   <= 1'b0;
            cwrAddr_q    <= '0;
            cwrData_q    <= '0;
            zDone_q      <= 1'b0;
            cDone_q      <= 1'b0;
            perfIn_q     <= '0;
            perfPassed_q <= '0;
            perfKilled_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (frag_valid) begin
                        perfIn_q   <= perfIn_q + 32'd1;
                        fragZ_q    <= frag_z;
                        color_q    <= frag_color;
                        func_q     <= depth_func_t'(depth_func);
                        zWriteEn_q <= depth_write_en;
                        zAddr_q    <= zAddr_d;
                        cAddr_q    <= cAddr_d;
                        if (!scissorKeep) begin
                            perfKilled_q <= perfKilled_q + 32'd1;
                        end else if (depth_test_en) begin
                            state_q    <= ST_ZREQ;
                            zrdValid_q <= 1'b1;
                            zrdAddr_q  <= zAddr_d;
                        end else begin
                            // No depth test: go straight to a colour-only write
                            state_q      <= ST_WRITE;
                            perfPassed_q <= perfPassed_q + 32'd1;
                            cwrValid_q   <= 1'b1;
                            cwrAddr_q    <= cAddr_d;
                            cwrData_q    <= frag_color;
                            cDone_q      <= 1'b0;
                            zDone_q      <= 1'b1;
                        end
                    end
                end
                ST_ZREQ: begin
                    if (zrd_req_ready) begin
                        zrdValid_q <= 1'b0;
                        state_q    <= ST_ZWAIT;
                    end
                end
                ST_ZWAIT: begin
                    if (zrd_rsp_valid) begin
                        storedZ_q <= zrd_rsp_data;
                        state_q   <= ST_TEST;
                    end
                end
                ST_TEST: begin
                    if (depthPass) begin
                        state_q      <= ST_WRITE;
                        perfPassed_q <= perfPassed_q + 32'd1;
                        cwrValid_q   <= 1'b1;
                        cwrAddr_q    <= cAddr_q;
                        cwrData_q    <= color_q;
                        cDone_q      <= 1'b0;
                        zwrValid_q   <= zWriteEn_q;
                        zwrAddr_q    <= zAddr_q;
                        zwrData_q    <= fragZ_q;
                        zDone_q      <= ~zWriteEn_q;
                    end else begin
                        state_q      <= ST_IDLE;
                        perfKilled_q <= perfKilled_q + 32'd1;
                    end
                end
                ST_WRITE: begin
                    if (zwrValid_q && zwr_ready) begin
                        zwrValid_q <= 1'b0;
                        zDone_q    <= 1'b1;
                    end
                    if (cwrValid_q && cwr_ready) begin
                        cwrValid_q <= 1'b0;
                        cDone_q    <= 1'b1;
                    end
                    if (zDoneNow && cDoneNow) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_frag_depth_rop.sv
// ---------------------------------------------------------------------------
// tb_frag_depth_rop
// Drives fragments into frag_depth_rop while a small memory model answers the
// Z read channel and absorbs both write channels. Expectations come from a
// per-fragment reference computation (address arithmetic, depth rule, and
// which writes must appear), compared against what the memory model saw.
// ---------------------------------------------------------------------------
module tb_frag_depth_rop;

    localparam int COORD_W   = 16;
    localparam int COLOR_W   = 32;
    localparam int ADDR_W    = 24;
    localparam longint AMASK = (64'd1 << ADDR_W) - 1;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               frag_valid = 1'b0;
    logic               frag_ready;
    logic [COORD_W-1:0] frag_x = '0;
    logic [COORD_W-1:0] frag_y = '0;
    logic [COORD_W-1:0] frag_z = '0;
    logic [COLOR_W-1:0] frag_color = '0;
    logic               depth_test_en = 1'b0;
    logic [2:0]         depth_func = '0;
    logic               depth_write_en = 1'b0;
    logic [COORD_W-1:0] fb_pitch = '0;
    logic [ADDR_W-1:0]  z_base = '0;
    logic [ADDR_W-1:0]  c_base = '0;
`ifdef FRAG_ROP_SCISSOR_EN
    logic [COORD_W-1:0] sc_x = '0;
    logic [COORD_W-1:0] sc_y = '0;
    logic [COORD_W-1:0] sc_w = 16'hFFFF;
    logic [COORD_W-1:0] sc_h = 16'hFFFF;
`endif
    logic               zrd_req_valid;
    logic               zrd_req_ready = 1'b0;
    logic [ADDR_W-1:0]  zrd_addr;
    logic               zrd_rsp_valid = 1'b0;
    logic [COORD_W-1:0] zrd_rsp_data = '0;
    logic               zwr_valid;
    logic               zwr_ready = 1'b0;
    logic [ADDR_W-1:0]  zwr_addr;
    logic [COORD_W-1:0] zwr_data;
    logic               cwr_valid;
    logic               cwr_ready = 1'b0;
    logic [ADDR_W-1:0]  cwr_addr;
    logic [COLOR_W-1:0] cwr_data;
    logic [31:0]        perf_frags_in;
    logic [31:0]        perf_frags_passed;
    logic [31:0]        perf_frags_killed;

    frag_depth_rop #(
        .COORD_W (COORD_W),
        .COLOR_W (COLOR_W),
        .ADDR_W  (ADDR_W)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .frag_valid        (frag_valid),
        .frag_ready        (frag_ready),
        .frag_x            (frag_x),
        .frag_y            (frag_y),
        .frag_z            (frag_z),
        .frag_color        (frag_color),
        .depth_test_en     (depth_test_en),
        .depth_func        (depth_func),
        .depth_write_en    (depth_write_en),
        .fb_pitch          (fb_pitch),
        .z_base            (z_base),
        .c_base            (c_base),
`ifdef FRAG_ROP_SCISSOR_EN
        .sc_x              (sc_x),
        .sc_y              (sc_y),
        .sc_w              (sc_w),
        .sc_h              (sc_h),
`endif
        .zrd_req_valid     (zrd_req_valid),
        .zrd_req_ready     (zrd_req_ready),
        .zrd_addr          (zrd_addr),
        .zrd_rsp_valid     (zrd_rsp_valid),
        .zrd_rsp_data      (zrd_rsp_data),
        .zwr_valid         (zwr_valid),
        .zwr_ready         (zwr_ready),
        .zwr_addr          (zwr_addr),
        .zwr_data          (zwr_data),
        .cwr_valid         (cwr_valid),
        .cwr_ready         (cwr_ready),
        .cwr_addr          (cwr_addr),
        .cwr_data          (cwr_data),
        .perf_frags_in     (perf_frags_in),
        .perf_frags_passed (perf_frags_passed),
        .perf_frags_killed (perf_frags_killed)
    );

    // Free-running clock and cycle index used to time handshakes
    always #5 clk = ~clk;

    int cycle = 0;
    always @(posedge clk) cycle <= cycle + 1;

    int checks = 0;
    int errors = 0;

    // Expected performance counters
    int expIn = 0;
    int expPassed = 0;
    int expKilled = 0;

    // Memory model state and what it observed for the current fragment
    logic [15:0]  zMem [int];
    int           zrdLog[$];
    logic [63:0]  zwrLog[$];
    logic [63:0]  cwrLog[$];
    int           pendAddr[$];
    int           pendDue[$];
    int           zwrValidCycles = 0;
    int           cwrValidCycles = 0;
    int           firstCwrCycle = -1;
    int           readyMode = 1;
    bit           rspHold = 1'b0;
    int           bpCount = 0;

    // Single comparison point: counts every check and reports a mismatch
    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h (cycle %0d)", tag, observed, expected, cycle);
        end
    endtask

    // Unwritten Z locations hold a deterministic pattern
    function automatic logic [15:0] memRead(input int a);
        if (zMem.exists(a)) return zMem[a];
        return 16'((a * 37 + 11) & 32'hFFFF);
    endfunction

    function automatic int calcAddr(input int base, input int x, input int y, input int pitch);
        longint full;
        full = longint'(y) * longint'(pitch) + longint'(x) + longint'(base);
        return int'(full & AMASK);
    endfunction

    // Depth rule straight from the function table
    function automatic bit modelPass(input int func, input int z, input int s);
        case (func)
            0: return 1'b0;
            1: return z < s;
            2: return z == s;
            3: return z <= s;
            4: return z > s;
            5: return z != s;
            6: return z >= s;
            default: return 1'b1;
        endcase
    endfunction

    // Memory side: picks readies, records handshakes, checks held outputs
    // during stalls and returns read data after a random latency
    initial begin : memoryModel
        bit          zrdStall = 1'b0;
        bit          zwrStall = 1'b0;
        bit          cwrStall = 1'b0;
        logic [63:0] zrdSaved = '0;
        logic [63:0] zwrSaved = '0;
        logic [63:0] cwrSaved = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                zrdStall = 1'b0;
                zwrStall = 1'b0;
                cwrStall = 1'b0;
            end
            if (zrdStall) checkOutput("zrd_hold", 64'({zrd_req_valid, zrd_addr}), zrdSaved);
            if (zwrStall) checkOutput("zwr_hold", 64'({zwr_valid, zwr_addr, zwr_data}), zwrSaved);
            if (cwrStall) checkOutput("cwr_hold", 64'({cwr_valid, cwr_addr, cwr_data}), cwrSaved);

            case (readyMode)
                0: begin
                    zrd_req_ready = ($urandom_range(0, 2) != 0);
                    zwr_ready     = ($urandom_range(0, 2) != 0);
                    cwr_ready     = ($urandom_range(0, 2) != 0);
                end
                2: begin
                    zrd_req_ready = 1'b1;
                    zwr_ready     = 1'b1;
                    cwr_ready     = cwr_valid && (bpCount >= 5);
                    if (cwr_valid) bpCount++;
                end
                default: begin
                    zrd_req_ready = 1'b1;
                    zwr_ready     = 1'b1;
                    cwr_ready     = 1'b1;
                end
            endcase

            if (zrd_req_valid && zrd_req_ready && !rst) begin
                zrdLog.push_back(int'(zrd_addr));
                pendAddr.push_back(int'(zrd_addr));
                pendDue.push_back(cycle + ((readyMode == 0) ? $urandom_range(1, 4) : 1));
            end
            zrdStall = zrd_req_valid && !zrd_req_ready && !rst;
            zrdSaved = 64'({zrd_req_valid, zrd_addr});

            if (zwr_valid && !rst) zwrValidCycles++;
            if (zwr_valid && zwr_ready && !rst) begin
                zwrLog.push_back(64'({zwr_addr, zwr_data}));
                zMem[int'(zwr_addr)] = zwr_data;
            end
            zwrStall = zwr_valid && !zwr_ready && !rst;
            zwrSaved = 64'({zwr_valid, zwr_addr, zwr_data});

            if (cwr_valid && !rst) begin
                cwrValidCycles++;
                if (firstCwrCycle < 0) firstCwrCycle = cycle;
            end
            if (cwr_valid && cwr_ready && !rst) cwrLog.push_back(64'({cwr_addr, cwr_data}));
            cwrStall = cwr_valid && !cwr_ready && !rst;
            cwrSaved = 64'({cwr_valid, cwr_addr, cwr_data});

            zrd_rsp_valid = 1'b0;
            zrd_rsp_data  = 16'($urandom);
            if (!rspHold && pendAddr.size() > 0 && pendDue[0] <= cycle) begin
                zrd_rsp_valid = 1'b1;
                zrd_rsp_data  = memRead(pendAddr[0]);
                void'(pendAddr.pop_front());
                void'(pendDue.pop_front());
            end
        end
    end

    function automatic bit scissorKeep(input int x, input int y);
`ifdef FRAG_ROP_SCISSOR_EN
        return (x >= int'(sc_x)) && (x < int'(sc_x) + int'(sc_w)) &&
               (y >= int'(sc_y)) && (y < int'(sc_y) + int'(sc_h));
`else
        return 1'b1;
`endif
    endfunction

    task automatic checkCounters(input string tag);
        checkOutput({tag, "_perf_in"}, 64'(perf_frags_in), 64'(expIn));
        checkOutput({tag, "_perf_passed"}, 64'(perf_frags_passed), 64'(expPassed));
        checkOutput({tag, "_perf_killed"}, 64'(perf_frags_killed), 64'(expKilled));
    endtask

    // Sends one fragment, waits for the ROP to go idle again, then checks the
    // memory traffic and counters against the reference computation
    task automatic applyStimulus(input string tag, input int x, input int y, input int zIn,
                                 input logic [31:0] color, input bit ten, input int func,
                                 input bit wen, input int pitch, input int zb, input int cb);
        int  z;
        int  zA;
        int  cA;
        int  stored;
        bit  keep;
        bit  pass;
        bit  doWrite;
        bit  doZ;
        int  guard;
        int  accCycle;
        int  doneCycle;

        z      = zIn & 32'hFFFF;
        zA     = calcAddr(zb, x, y, pitch);
        cA     = calcAddr(cb, x, y, pitch);
        keep   = scissorKeep(x, y);
        stored = int'(memRead(zA));
        pass   = modelPass(func, z, stored);
        doWrite = keep && (!ten || pass);
        doZ     = doWrite && ten && wen;

        zrdLog.delete();
        zwrLog.delete();
        cwrLog.delete();
        zwrValidCycles = 0;
        cwrValidCycles = 0;
        firstCwrCycle  = -1;
        bpCount        = 0;

        @(negedge clk);
        #1;
        frag_valid     = 1'b1;
        frag_x         = 16'(x);
        frag_y         = 16'(y);
        frag_z         = 16'(z);
        frag_color     = color;
        depth_test_en  = ten;
        depth_func     = 3'(func);
        depth_write_en = wen;
        fb_pitch       = 16'(pitch);
        z_base         = 24'(zb);
        c_base         = 24'(cb);
        guard = 0;
        while (!frag_ready && guard < 100) begin
            @(negedge clk);
            #1;
            guard++;
        end
        checkOutput({tag, "_accept"}, 64'(frag_ready), 64'd1);
        accCycle = cycle;
        expIn++;
        if (!keep) expKilled++;
        else if (doWrite) expPassed++;
        else expKilled++;

        // Scramble the inputs after the accept: the fragment must already be latched
        @(negedge clk);
        #1;
        frag_valid     = 1'b0;
        frag_z         = 16'($urandom);
        frag_color     = $urandom;
        depth_func     = 3'($urandom);
        depth_write_en = 1'($urandom);
        z_base         = 24'($urandom);
        c_base         = 24'($urandom);
        guard = 0;
        while (!frag_ready && guard < 300) begin
            @(negedge clk);
            #1;
            guard++;
        end
        checkOutput({tag, "_done"}, 64'(frag_ready), 64'd1);
        doneCycle = cycle;

        checkOutput({tag, "_zrd_count"}, 64'(zrdLog.size()), 64'(ten && keep));
        if (zrdLog.size() > 0) checkOutput({tag, "_zrd_addr"}, 64'(zrdLog[0]), 64'(zA));
        checkOutput({tag, "_cwr_count"}, 64'(cwrLog.size()), 64'(doWrite));
        if (cwrLog.size() > 0) checkOutput({tag, "_cwr_txn"}, cwrLog[0], {8'd0, 24'(cA), color});
        checkOutput({tag, "_zwr_count"}, 64'(zwrLog.size()), 64'(doZ));
        if (zwrLog.size() > 0) checkOutput({tag, "_zwr_txn"}, zwrLog[0], {24'd0, 24'(zA), 16'(z)});
        checkCounters(tag);

        // With every channel always ready and single-cycle read latency the timing is fixed
        if (readyMode == 1) begin
            if (!keep)
                checkOutput({tag, "_latency"}, 64'(doneCycle - accCycle), 64'd1);
            else if (!ten)
                checkOutput({tag, "_latency"}, 64'(doneCycle - accCycle), 64'd2);
            else if (!pass)
                checkOutput({tag, "_latency"}, 64'(doneCycle - accCycle), 64'd4);
            else
                checkOutput({tag, "_latency"}, 64'(doneCycle - accCycle), 64'd5);
            if (doWrite)
                checkOutput({tag, "_cwr_start"}, 64'(firstCwrCycle - accCycle), ten ? 64'd4 : 64'd1);
        end
        if (readyMode == 2 && doWrite) begin
            checkOutput({tag, "_cwr_valid_cycles"}, 64'(cwrValidCycles), 64'd6);
            checkOutput({tag, "_zwr_valid_cycles"}, 64'(zwrValidCycles), 64'(doZ));
        end
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_frag_ready"}, 64'(frag_ready), 64'd1);
        checkOutput({tag, "_valids"}, 64'({zrd_req_valid, zwr_valid, cwr_valid}), 64'd0);
        checkOutput({tag, "_zrd_addr"}, 64'(zrd_addr), 64'd0);
        checkOutput({tag, "_zwr_bus"}, 64'({zwr_addr, zwr_data}), 64'd0);
        checkOutput({tag, "_cwr_bus"}, 64'({cwr_addr, cwr_data}), 64'd0);
        checkCounters(tag);
    endtask

    // Abort a fragment while it waits for Z data, then deliver the stale response
    task automatic resetMidFlight();
        int guard;
        readyMode = 1;
        rspHold   = 1'b1;
        zrdLog.delete();
        zwrLog.delete();
        cwrLog.delete();
        @(negedge clk);
        #1;
        frag_valid     = 1'b1;
        frag_x         = 16'd5;
        frag_y         = 16'd1;
        frag_z         = 16'd0;
        depth_test_en  = 1'b1;
        depth_func     = 3'd7;
        depth_write_en = 1'b1;
        fb_pitch       = 16'd64;
        @(negedge clk);
        #1;
        frag_valid = 1'b0;
        guard = 0;
        while (zrdLog.size() == 0 && guard < 50) begin
            @(negedge clk);
            #1;
            guard++;
        end
        checkOutput("rst_zrd_seen", 64'(zrdLog.size()), 64'd1);
        @(negedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        #1;
        rst     = 1'b0;
        rspHold = 1'b0;
        expIn = 0;
        expPassed = 0;
        expKilled = 0;
        repeat (3) begin
            @(negedge clk);
            #1;
        end
        checkOutput("rst_rsp_consumed", 64'(pendAddr.size()), 64'd0);
        checkOutput("rst_no_writes", 64'(zwrLog.size() + cwrLog.size()), 64'd0);
        checkResetOutputs("rst_mid");
    endtask

    initial begin : mainSequence
        int x;
        int y;
        int zb;
        int pitch;
        int stored;
        int z;
        int pitchTable[3];
        pitchTable[0] = 8;
        pitchTable[1] = 640;
        pitchTable[2] = 65535;

        repeat (3) @(negedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        #1;
        checkResetOutputs("reset");

        // Depth LESS pass, then fail at the same pixel
        readyMode = 1;
        zMem[32'h1503] = 16'h0200;
        applyStimulus("less_pass", 3, 2, 16'h0100, 32'hCAFE0001, 1'b1, 1, 1'b1, 640, 32'h1000, 32'h20000);
        zMem[32'h1503] = 16'h0080;
        applyStimulus("less_fail", 3, 2, 16'h0100, 32'hCAFE0002, 1'b1, 1, 1'b1, 640, 32'h1000, 32'h20000);

        // Depth test disabled: colour-only write
        applyStimulus("no_test", 0, 1, 16'h1234, 32'hBEEF0003, 1'b0, 0, 1'b1, 640, 32'h1000, 32'h8000);

        // Colour write back-pressured for five cycles, Z write accepted at once
        readyMode = 2;
        zMem[32'h1503] = 16'h0200;
        applyStimulus("backpressure", 3, 2, 16'h0100, 32'hBEEF0004, 1'b1, 1, 1'b1, 640, 32'h1000, 32'h20000);

        // Every compare function around the stored depth
        readyMode = 1;
        for (int f = 0; f < 8; f++) begin
            for (int d = -1; d <= 1; d++) begin
                zMem[32'h2000 + f] = 16'h4000;
                applyStimulus($sformatf("func%0d_d%0d", f, d), f, 0, 16'h4000 + d, $urandom,
                              1'b1, f, 1'b1, 16, 32'h2000, 32'h30000);
            end
        end

`ifdef FRAG_ROP_SCISSOR_EN
        sc_x = 16'd10;
        sc_y = 16'd10;
        sc_w = 16'd4;
        sc_h = 16'd4;
        applyStimulus("scissor_out", 14, 10, 16'h0001, 32'h5C155001, 1'b1, 7, 1'b1, 640, 32'h1000, 32'h8000);
        applyStimulus("scissor_in", 13, 13, 16'h0001, 32'h5C155002, 1'b1, 7, 1'b1, 640, 32'h1000, 32'h8000);
`endif

        // Randomized traffic with random readies and read latency
        readyMode = 0;
        for (int i = 0; i < 150; i++) begin
`ifdef FRAG_ROP_SCISSOR_EN
            sc_x = 16'($urandom_range(0, 3));
            sc_y = 16'($urandom_range(0, 3));
            sc_w = 16'($urandom_range(0, 8));
            sc_h = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom_range(0, 8));
`endif
            x     = $urandom_range(0, 7);
            y     = $urandom_range(0, 7);
            pitch = pitchTable[$urandom_range(0, 2)];
            zb    = ($urandom_range(0, 1) == 0) ? 32'h1000 : 32'hFFFF00;
            stored = int'(memRead(calcAddr(zb, x, y, pitch)));
            z = ($urandom_range(0, 1) == 0) ? stored + $urandom_range(0, 2) - 1 : int'($urandom_range(0, 65535));
            applyStimulus($sformatf("rand%0d", i), x, y, z, $urandom, 1'($urandom_range(0, 3) != 0),
                          $urandom_range(0, 7), 1'($urandom), pitch, zb, int'($urandom & 32'hFFFFFF));
        end

        resetMidFlight();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
